// File: rtl/fetch_pkg.sv
// Shared types and constants for the wide instruction-fetch stage.
package fetch_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_wide_if.sv
// Fetch-stage bus: memory request/response plus the one-instruction decode port.
interface fetch_wide_if #(
    parameter int FETCH_WIDTH = 2
);
    import fetch_pkg::*;

    logic                            STALL;
    logic                            Request_Alt_PC;
    logic [31:0]                     Alt_PC;
    logic [31:0]                     Instr_address_2IM;
    logic [WORD_W*FETCH_WIDTH-1:0]   Instr_fIM;
    logic                            Instr_fIM_IsValid;
    logic [31:0]                     Instr1_OUT;
    logic [31:0]                     Instr_PC_OUT;
    logic [31:0]                     Instr_PC_Plus4;
    logic                            Instr1_Available;

    // master = the fetch stage, slave = memory/decode environment
    modport master (
        input  STALL, Request_Alt_PC, Alt_PC, Instr_fIM, Instr_fIM_IsValid,
        output Instr_address_2IM, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Instr1_Available
    );

    modport slave (
        output STALL, Request_Alt_PC, Alt_PC, Instr_fIM, Instr_fIM_IsValid,
        input  Instr_address_2IM, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4, Instr1_Available
    );

endinterface

// File: rtl/fetch_ring.sv
// Circular fetch queue: up to FETCH_WIDTH writes per cycle, one read, flush, head port.
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int QUEUE_DEPTH = 8,
    localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1),
    localparam int WC_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         flush_i,
    input  logic [WC_W-1:0] wr_cnt_i,
    input  fetch_entry_t wr_data_i [FETCH_WIDTH],
    input  logic         rd_en_i,
    output fetch_entry_t head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    fetch_entry_t       mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W-1:0]   wr_base;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rd_fire;

    // A flush rewinds both pointers, so the same-cycle group lands at slot 0.
    assign wr_base = flush_i ? '0 : tail_q;
    assign rd_fire = rd_en_i && !flush_i && (count_q != '0);

    always_comb begin
        head_d  = flush_i ? '0 : head_q + PTR_W'(rd_fire);
        tail_d  = wr_base + PTR_W'(wr_cnt_i);
        count_d = (flush_i ? '0 : count_q - CNT_W'(rd_fire)) + CNT_W'(wr_cnt_i);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (k < int'(wr_cnt_i)) begin
                    mem_q[wr_base + PTR_W'(k)] <= wr_data_i[k];
                end
            end
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_wide.sv
// Buffered wide instruction fetch: FETCH_WIDTH words in, one instruction out per cycle.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_BYPASS_EN.
module fetch_wide
    import fetch_pkg::*;
#(
    parameter int          FETCH_WIDTH = 2,
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_wide_if.master  bus
);

    localparam int          OFF_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int          CNT_W       = $clog2(QUEUE_DEPTH + 1);
    localparam int          WC_W        = $clog2(FETCH_WIDTH + 1);
    localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_WIDTH);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        addr;
    logic [31:0]        group_base;
    logic [OFF_W-1:0]   off;
    logic [31:0]        word [FETCH_WIDTH];
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     free_slots;
    logic               queue_empty;
    logic               enq_fire;
    logic               bypass_act;
    logic               bypass_take;
    logic [WC_W-1:0]    first_idx;
    logic [WC_W-1:0]    wr_cnt;
    logic               rd_en;
    fetch_entry_t       wr_data [FETCH_WIDTH];
    fetch_entry_t       head;

    assign addr       = bus.Request_Alt_PC ? bus.Alt_PC : fetch_pc_q;
    assign group_base = addr & ~(GROUP_BYTES - 32'd1);
    assign bus.Instr_address_2IM = addr;

    generate
        if (FETCH_WIDTH > 1) begin : g_off
            assign off = addr[OFF_W+1:2];
        end else begin : g_off1
            assign off = '0;
        end
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_word
            assign word[gi] = bus.Instr_fIM[WORD_W*gi +: WORD_W];
        end
    endgenerate

    // Free space is judged on the start-of-cycle count; a flush empties the queue first.
    assign queue_empty = (count == '0);
    assign free_slots  = (CNT_W+1)'(QUEUE_DEPTH) - {1'b0, count};
    assign enq_fire    = bus.Instr_fIM_IsValid &&
                         (bus.Request_Alt_PC || (free_slots >= (CNT_W+1)'(FETCH_WIDTH)));

`ifdef FETCH_BYPASS_EN
    assign bypass_act  = queue_empty && !bus.Request_Alt_PC && bus.Instr_fIM_IsValid;
    assign bypass_take = bypass_act && !bus.STALL;
`else
    assign bypass_act  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // A bypassed word that decode accepts is skipped when the group is written.
    assign first_idx = WC_W'(off) + WC_W'(bypass_take);
    assign wr_cnt    = enq_fire ? (WC_W'(FETCH_WIDTH) - first_idx) : '0;
    assign rd_en     = !queue_empty && !bus.Request_Alt_PC && !bus.STALL;

    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr
            logic [WC_W:0] src;
            always_comb begin
                src         = {1'b0, first_idx} + (WC_W+1)'(gi);
                wr_data[gi] = '0;
                if (src < (WC_W+1)'(FETCH_WIDTH)) begin
                    wr_data[gi].pc    = group_base + (32'(src) << 2);
                    wr_data[gi].instr = word[src[OFF_W-1:0]];
                end
            end
        end
    endgenerate

    fetch_ring #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_ring (
        .clk       (CLK),
        .srst      (RESET),
        .flush_i   (bus.Request_Alt_PC),
        .wr_cnt_i  (wr_cnt),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .head_o    (head),
        .count_o   (count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (enq_fire) begin
            fetch_pc_d = group_base + GROUP_BYTES;
        end else if (bus.Request_Alt_PC) begin
            fetch_pc_d = bus.Alt_PC;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        bus.Instr1_OUT       = '0;
        bus.Instr_PC_OUT     = '0;
        bus.Instr_PC_Plus4   = '0;
        bus.Instr1_Available = (!queue_empty && !bus.Request_Alt_PC) || bypass_act;
        if (bypass_act) begin
            bus.Instr1_OUT     = word[off];
            bus.Instr_PC_OUT   = group_base + (32'(off) << 2);
            bus.Instr_PC_Plus4 = pc_plus4(group_base + (32'(off) << 2));
        end else if (!queue_empty) begin
            bus.Instr1_OUT     = head.instr;
            bus.Instr_PC_OUT   = head.pc;
            bus.Instr_PC_Plus4 = pc_plus4(head.pc);
        end
    end

endmodule

// File: tb/tb_fetch_wide.sv
// Directed bench for fetch_wide (W=2, D=4) with an in-order PC scoreboard.
module tb_fetch_wide;
    import fetch_pkg::*;

    localparam int W = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_wide_if #(.FETCH_WIDTH(W)) bus ();

    fetch_wide #(
        .FETCH_WIDTH (W),
        .QUEUE_DEPTH (D),
        .RESET_PC    (32'hBFC0_0000)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {pc[7:0], pc[31:8]} ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory: returns the aligned group holding the requested address.
    logic [31:0] mem_base;
    always_comb begin
        mem_base      = bus.Instr_address_2IM & ~32'(4*W - 1);
        bus.Instr_fIM = '0;
        for (int i = 0; i < W; i++) begin
            bus.Instr_fIM[32*i +: 32] = mem_word(mem_base + 32'(4*i));
        end
    end

    logic [31:0] exp_q [$];
    int checks    = 0;
    int errors    = 0;
    int delivered = 0;
    int d0        = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(pc + 32'(4*i));
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (bus.Instr1_Available === 1'b1 && bus.STALL === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL deq_unexpected observed=%h expected=none", bus.Instr_PC_OUT);
            end else begin
                e = exp_q.pop_front();
                $display("deq pc=%h instr=%h (exp pc=%h)", bus.Instr_PC_OUT, bus.Instr1_OUT, e);
                chk("deq_pc", bus.Instr_PC_OUT, e);
                chk("deq_instr", bus.Instr1_OUT, mem_word(e));
                chk("deq_pc4", bus.Instr_PC_Plus4, e + 32'd4);
                delivered++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.STALL             = 1'b0;
        bus.Request_Alt_PC    = 1'b0;
        bus.Alt_PC            = 32'h0;
        bus.Instr_fIM_IsValid = 1'b0;
        tick();
        tick();
        chk("reset_addr",  bus.Instr_address_2IM, 32'hBFC0_0000);
        chk("reset_avail", 32'(bus.Instr1_Available), 32'd0);
        chk("reset_instr", bus.Instr1_OUT, 32'h0);
        chk("reset_pc",    bus.Instr_PC_OUT, 32'h0);
        chk("reset_pc4",   bus.Instr_PC_Plus4, 32'h0);

        // Start-up: first group lands one cycle after release.
        rst                   = 1'b0;
        bus.Instr_fIM_IsValid = 1'b1;
        bus.STALL             = 1'b1;
        restart_stream(32'hBFC0_0000);
        #1;
        chk("p1_addr", bus.Instr_address_2IM, 32'hBFC0_0000);
`ifndef FETCH_BYPASS_EN
        chk("p1_avail_same", 32'(bus.Instr1_Available), 32'd0);
`endif
        tick();
        chk("p1_avail",   32'(bus.Instr1_Available), 32'd1);
        chk("p1_head_pc", bus.Instr_PC_OUT, 32'hBFC0_0000);
        chk("p1_instr",   bus.Instr1_OUT, mem_word(32'hBFC0_0000));
        chk("p1_addr2",   bus.Instr_address_2IM, 32'hBFC0_0008);

        // Backpressure until full, then release.
        tick();
        chk("p2_addr_full", bus.Instr_address_2IM, 32'hBFC0_0010);
        tick();
        chk("p2_addr_hold1", bus.Instr_address_2IM, 32'hBFC0_0010);
        tick();
        chk("p2_addr_hold2", bus.Instr_address_2IM, 32'hBFC0_0010);
        chk("p2_head_hold",  bus.Instr_PC_OUT, 32'hBFC0_0000);
        bus.STALL = 1'b0;
        tick();
        tick();
        tick();
        chk("p2_addr_resume", bus.Instr_address_2IM, 32'hBFC0_0018);
        chk("p2_delivered",   32'(delivered), 32'd3);

        // Unaligned redirect with three entries queued, under stall.
        bus.STALL          = 1'b1;
        bus.Request_Alt_PC = 1'b1;
        bus.Alt_PC         = 32'hBFC0_0104;
        restart_stream(32'hBFC0_0104);
        #1;
        chk("p3_avail", 32'(bus.Instr1_Available), 32'd0);
        chk("p3_addr",  bus.Instr_address_2IM, 32'hBFC0_0104);
        tick();
        bus.Request_Alt_PC    = 1'b0;
        bus.Instr_fIM_IsValid = 1'b0;
        #1;
        chk("p3_head",      bus.Instr_PC_OUT, 32'hBFC0_0104);
        chk("p3_next_addr", bus.Instr_address_2IM, 32'hBFC0_0108);
        chk("p3_avail2",    32'(bus.Instr1_Available), 32'd1);

        // Memory not valid: nothing moves.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("p4_addr", bus.Instr_address_2IM, 32'hBFC0_0108);
            chk("p4_head", bus.Instr_PC_OUT, 32'hBFC0_0104);
        end
        bus.STALL = 1'b0;
        tick();
        chk("p4_drained", 32'(bus.Instr1_Available), 32'd0);
        chk("p4_addr2",   bus.Instr_address_2IM, 32'hBFC0_0108);

        // Long stream with alternating stall wraps the pointers many times.
        bus.Instr_fIM_IsValid = 1'b1;
        d0 = delivered;
        for (int c = 0; c < 100; c++) begin
            bus.STALL = c[0];
            tick();
        end
        bus.STALL             = 1'b0;
        bus.Instr_fIM_IsValid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("p5_count",   32'(delivered - d0 >= 40), 32'd1);
        chk("p5_avail",   32'(bus.Instr1_Available), 32'd0);
        chk("p5_no_drop", bus.Instr_address_2IM, (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);

`ifdef FETCH_BYPASS_EN
        bus.STALL          = 1'b1;
        bus.Request_Alt_PC = 1'b1;
        bus.Alt_PC         = 32'hBFC0_0200;
        restart_stream(32'hBFC0_0200);
        tick();
        bus.Request_Alt_PC    = 1'b0;
        bus.Instr_fIM_IsValid = 1'b1;
        bus.STALL             = 1'b0;
        #1;
        chk("p6_byp_avail", 32'(bus.Instr1_Available), 32'd1);
        chk("p6_byp_pc",    bus.Instr_PC_OUT, 32'hBFC0_0200);
        tick();
        bus.STALL = 1'b1;
        #1;
        chk("p6_next_pc", bus.Instr_PC_OUT, 32'hBFC0_0204);
`endif

        // Reset beats a simultaneous redirect.
        bus.STALL             = 1'b0;
        bus.Instr_fIM_IsValid = 1'b1;
        rst                   = 1'b1;
        bus.Request_Alt_PC    = 1'b1;
        bus.Alt_PC            = 32'h0000_1000;
        tick();
        bus.Request_Alt_PC = 1'b0;
        #1;
        chk("rst2_addr",  bus.Instr_address_2IM, 32'hBFC0_0000);
        chk("rst2_avail", 32'(bus.Instr1_Available), 32'd0);
        chk("rst2_pc",    bus.Instr_PC_OUT, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
